// File: rtl/pipe_fetch_unit.sv
// pipe_fetch_unit: IF stage owning the PC, issuing in-order imem requests and buffering instructions.
// Define FETCH_PERF_EN to add the perf_redirects / perf_starve counter outputs.
module pipe_fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_starve
`endif
);

    localparam int unsigned AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [XLEN-1:0]     r_fetch_pc;
    logic [PW-1:0]       r_alloc_ptr;
    logic [PW-1:0]       r_fill_ptr;
    logic [PW-1:0]       r_head_ptr;
    logic [PW-1:0]       r_drop_cnt;
    logic [XLEN-1:0]     r_slot_pc    [FQ_DEPTH];
    logic [ILEN-1:0]     r_slot_instr [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] r_filled;
    logic [ILEN-1:0]     r_hold_instr;
    logic [XLEN-1:0]     r_hold_pc;

    logic [PW-1:0]       w_alloc_cnt;
    logic [PW-1:0]       w_outstanding;
    logic [PW-1:0]       w_rsp_inc;
    logic [PW-1:0]       w_drop_nxt;
    logic [AW-1:0]       w_alloc_idx;
    logic [AW-1:0]       w_fill_idx;
    logic [AW-1:0]       w_head_idx;
    logic                w_head_filled;
    logic                w_req_valid;
    logic                w_flush;
    logic                w_req_fire;
    logic                w_rsp_fill;
    logic                w_deq;
    logic [XLEN-1:0]     w_redirect_aligned;

    // Pointers carry one wrap bit so occupancy is a plain subtraction.
    assign w_alloc_cnt        = r_alloc_ptr - r_head_ptr;
    assign w_outstanding      = r_alloc_ptr - r_fill_ptr;
    assign w_alloc_idx        = r_alloc_ptr[AW-1:0];
    assign w_fill_idx         = r_fill_ptr[AW-1:0];
    assign w_head_idx         = r_head_ptr[AW-1:0];
    assign w_head_filled      = r_filled[w_head_idx];
    assign w_rsp_inc          = imem_rsp_valid ? PW'(1) : '0;
    assign w_redirect_aligned = redirect_pc & ~XLEN'(3);

    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop_cnt;
        w_req_valid = 1'b0;
        w_flush     = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_req_valid = (w_alloc_cnt < PW'(FQ_DEPTH)) && !redirect_valid;
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    // A same-cycle response belongs to the wrong path and counts as already dropped.
                    if (w_outstanding > w_rsp_inc) begin
                        w_drop_nxt  = w_outstanding - w_rsp_inc;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_drop_nxt  = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                    w_drop_nxt = r_drop_cnt - PW'(1);
                    if (r_drop_cnt == PW'(1)) begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign imem_req_valid = w_req_valid && !reset;
    assign imem_req_addr  = reset ? RESET_PC : r_fetch_pc;
    assign id_valid       = w_head_filled && !redirect_valid && !reset;
    assign id_instr       = reset ? '0 : (w_head_filled ? r_slot_instr[w_head_idx] : r_hold_instr);
    assign id_pc          = reset ? '0 : (w_head_filled ? r_slot_pc[w_head_idx] : r_hold_pc);

    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp_fill = imem_rsp_valid && (r_state == S_FETCH) && !redirect_valid &&
                        (w_outstanding != '0);
    assign w_deq      = id_valid && id_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc   <= RESET_PC;
            r_alloc_ptr  <= '0;
            r_fill_ptr   <= '0;
            r_head_ptr   <= '0;
            r_drop_cnt   <= '0;
            r_filled     <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            r_drop_cnt   <= w_drop_nxt;
            r_hold_instr <= id_instr;
            r_hold_pc    <= id_pc;

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_aligned;
            end else if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end

            if (w_flush) begin
                r_alloc_ptr <= '0;
                r_fill_ptr  <= '0;
                r_head_ptr  <= '0;
                r_filled    <= '0;
            end else begin
                if (w_req_fire) begin
                    r_alloc_ptr <= r_alloc_ptr + PW'(1);
                end
                // Fill and head slots are always distinct, so set/clear never collide.
                if (w_rsp_fill) begin
                    r_filled[w_fill_idx] <= 1'b1;
                    r_fill_ptr           <= r_fill_ptr + PW'(1);
                end
                if (w_deq) begin
                    r_filled[w_head_idx] <= 1'b0;
                    r_head_ptr           <= r_head_ptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_slot_pc[w_alloc_idx] <= r_fetch_pc;
        end
        if (w_rsp_fill) begin
            r_slot_instr[w_fill_idx] <= imem_rsp_data;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_redirects <= '0;
            perf_starve    <= '0;
        end else begin
            if (redirect_valid) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if (id_ready && !id_valid) begin
                perf_starve <= perf_starve + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // A response with nothing outstanding is an imem protocol violation; the RTL ignores it.
    a_rsp_without_req: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && (r_state == S_FETCH) && (w_outstanding == '0)));
`endif

endmodule
